alu_mem_datapath: RTL and testbench

- Execution-side responder to the control unit. It consumes operand1/operand2/offset/opcode/sel1/sel3/w_r and returns result2.
- Contains the ALU, a registered ALU result stage, the data memory (2^ADDR_BITS x DATA_WIDTH), the result2 source mux and the ALU flag registers.
- Timing is fixed to the CU FSM:
  - std_op: result2 is valid one edge after the operands are presented (captured at WRITE_BACK).
  - loadR/storeR: memory access completes on the second edge.

---
 rtl/alu_mem_datapath.sv | 169 ++++++++++++++++
 tb/tb_alu_mem_datapath.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_datapath.sv
// alu_mem_datapath: ALU, registered result stage, data memory and result2 mux.
// Ports: clk, rst (sync, active-low), operand1/operand2/offset/opcode/sel1/sel3/w_r in;
// result2, zero_flag, carry_flag out. Optional macro DP_MEM_INIT_EN: reset loads mem[i]=i.
module alu_mem_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero_flag,
    output logic                  carry_flag
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [DATA_WIDTH:0] ONE = (DATA_WIDTH+1)'(1);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOT   = 4'b0101,
        OP_SHL   = 4'b0110,
        OP_SHR   = 4'b0111,
        OP_PASSA = 4'b1000,
        OP_PASSB = 4'b1001,
        OP_INC   = 4'b1010,
        OP_DEC   = 4'b1011,
        OP_NOP   = 4'b1111
    } op_e;

    op_e op;
    assign op = op_e'(opcode);

    // ALU
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH:0]   ext_a;
    logic [DATA_WIDTH:0]   ext_b;
    logic [DATA_WIDTH:0]   wide;
    logic                  arith;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_cry;

    always_comb begin
        alu_b = sel3 ? offset : operand2;
        ext_a = {1'b0, operand1};
        ext_b = {1'b0, alu_b};
        wide  = ext_a;
        arith = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = ext_a + ext_b;
                arith = 1'b1;
            end
            OP_SUB: begin
                // zero-extended subtraction: top bit is the borrow
                wide  = ext_a - ext_b;
                arith = 1'b1;
            end
            OP_AND:   wide = {1'b0, operand1 & alu_b};
            OP_OR:    wide = {1'b0, operand1 | alu_b};
            OP_XOR:   wide = {1'b0, operand1 ^ alu_b};
            OP_NOT:   wide = {1'b0, ~operand1};
            OP_SHL:   wide = {1'b0, operand1 << alu_b[2:0]};
            OP_SHR:   wide = {1'b0, operand1 >> alu_b[2:0]};
            OP_PASSA: wide = ext_a;
            OP_PASSB: wide = ext_b;
            OP_INC: begin
                wide  = ext_a + ONE;
                arith = 1'b1;
            end
            OP_DEC: begin
                wide  = ext_a - ONE;
                arith = 1'b1;
            end
            // 1100-1110 alias PASS A; NOP result is discarded
            default:  wide = ext_a;
        endcase
        alu_res = wide[DATA_WIDTH-1:0];
        alu_cry = arith & wide[DATA_WIDTH];
    end

    // Stage 1 registers
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  sel1_q, sel1_d;
    logic                  w_r_q, w_r_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;

    always_comb begin
        alu_d   = alu_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        w_r_d   = 1'b0;
        sel1_d  = sel1;
        wdata_d = operand2;
        if (op != OP_NOP) begin
            alu_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_cry;
            w_r_d   = w_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_q   <= '0;
            wdata_q <= '0;
            sel1_q  <= 1'b1;
            w_r_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            sel1_q  <= sel1_d;
            w_r_q   <= w_r_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Stage 2: data memory, read-first
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q;
    logic [ADDR_BITS-1:0]  addr;

    assign addr = alu_q[ADDR_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem[addr];
        end
    end

    // a store pending in w_r_q is dropped when reset hits
    always_ff @(posedge clk) begin
`ifdef DP_MEM_INIT_EN
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
        end else if (w_r_q) begin
            mem[addr] <= wdata_q;
        end
`else
        if (rst && w_r_q) begin
            mem[addr] <= wdata_q;
        end
`endif
    end

    assign result2    = sel1_q ? alu_q : mem_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_mem_datapath.sv
// tb_alu_mem_datapath: directed vectors, literal checks and a
// per-cycle comparison against an arithmetic reference model.
module tb_alu_mem_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] operand1, operand2, offset;
    logic [3:0] opcode;
    logic       sel1, sel3, w_r;
    logic [7:0] result2;
    logic       zero_flag, carry_flag;

    int total = 0;
    int bad   = 0;

    alu_mem_datapath #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .operand1(operand1), .operand2(operand2), .offset(offset),
        .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
        .result2(result2), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: what each register-visible quantity must be
    int   m_alu, m_mem, m_data;
    bit   m_sel1, m_pend, m_z, m_c, m_memk;
    bit   m_live = 1'b0;
    int   mm [32];
    bit   kn [32];

    function automatic void alu_ref(input int op, input int a, input int b,
                                    output int r, output bit c, output bit upd);
        r = a; c = 1'b0; upd = 1'b1;
        case (op)
            0:  begin r = a + b; c = (r > 255); end
            1:  begin r = a - b; c = (a < b); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  r = a * (1 << (b % 8));
            7:  r = a / (1 << (b % 8));
            9:  r = b;
            10: begin r = a + 1; c = (a == 255); end
            11: begin r = a - 1; c = (a == 0); end
            15: upd = 1'b0;
            default: r = a;
        endcase
        r = r & 255;
    endfunction

    always @(posedge clk) begin
        int r, a, b, ad;
        bit c, upd;
        if (!rst) begin
            m_alu = 0; m_mem = 0; m_memk = 1'b1; m_data = 0;
            m_sel1 = 1'b1; m_pend = 1'b0; m_z = 1'b0; m_c = 1'b0;
`ifdef DP_MEM_INIT_EN
            for (int i = 0; i < 32; i++) begin
                mm[i] = i; kn[i] = 1'b1;
            end
`endif
            m_live = 1'b1;
        end else begin
            ad = m_alu % 32;
            m_mem  = mm[ad];
            m_memk = kn[ad];
            if (m_pend) begin
                mm[ad] = m_data; kn[ad] = 1'b1;
            end
            a = int'(operand1);
            b = sel3 ? int'(offset) : int'(operand2);
            alu_ref(int'(opcode), a, b, r, c, upd);
            if (upd) begin
                m_alu = r; m_z = (r == 0); m_c = c; m_pend = w_r;
            end else begin
                m_pend = 1'b0;
            end
            m_data = int'(operand2);
            m_sel1 = sel1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            if (m_sel1) chk("model_r2_alu", result2, m_alu);
            else if (m_memk) chk("model_r2_mem", result2, m_mem);
            chk("model_zero", zero_flag, m_z);
            chk("model_carry", carry_flag, m_c);
        end
    end

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] off, input logic s1, input logic s3, input logic wr);
        opcode = op; operand1 = a; operand2 = b; offset = off;
        sel1 = s1; sel3 = s3; w_r = wr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       z;
        logic       c;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl = '{
            '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0},
            '{4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0},
            '{4'h4, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0},
            '{4'h5, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0},
            '{4'h6, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0},
            '{4'h7, 8'h81, 8'h02, 8'h20, 1'b0, 1'b0},
            '{4'h8, 8'h00, 8'h55, 8'h00, 1'b1, 1'b0},
            '{4'h9, 8'h11, 8'h42, 8'h42, 1'b0, 1'b0},
            '{4'hA, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1},
            '{4'hB, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1},
            '{4'hC, 8'h33, 8'h01, 8'h33, 1'b0, 1'b0},
            '{4'hE, 8'h44, 8'h01, 8'h44, 1'b0, 1'b0},
            '{4'h0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1}
        };

        // reset with arbitrary inputs, including a store request
        rst = 1'b0;
        drive(4'h0, 8'h55, 8'h66, 8'h77, 1'b0, 1'b1, 1'b1);
        tick(2);
        chk("reset_r2", result2, 8'h00);
        chk("reset_zero", zero_flag, 1'b0);
        chk("reset_carry", carry_flag, 1'b0);
        rst = 1'b1;

`ifdef DP_MEM_INIT_EN
        drive(4'h8, 8'd7, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk("init_load7", result2, 8'd7);
`endif

        // std_op ADD / SUB
        drive(4'h0, 8'd5, 8'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("add_r2", result2, 8'd8);
        chk("add_zero", zero_flag, 1'b0);
        chk("add_carry", carry_flag, 1'b0);
        drive(4'h1, 8'd3, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("sub_r2", result2, 8'hFE);
        chk("sub_carry", carry_flag, 1'b1);

        // remaining opcodes
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, 8'h00, 1'b1, 1'b0, 1'b0);
            tick(1);
            chk($sformatf("op%0h_r2", tbl[i].op), result2, tbl[i].r);
            chk($sformatf("op%0h_zero", tbl[i].op), zero_flag, tbl[i].z);
            chk($sformatf("op%0h_carry", tbl[i].op), carry_flag, tbl[i].c);
        end

        // store 0xA5 at 2+4, then load it back
        drive(4'h0, 8'd2, 8'hA5, 8'd4, 1'b1, 1'b1, 1'b1);
        tick(3);
        chk("store_addr_r2", result2, 8'd6);
        drive(4'h0, 8'd2, 8'h00, 8'd4, 1'b0, 1'b1, 1'b0);
        tick(2);
        chk("load_a5", result2, 8'hA5);

        // wrap-around: 30+5 -> word 3
        drive(4'h0, 8'd30, 8'h3C, 8'd5, 1'b1, 1'b1, 1'b1);
        tick(3);
        drive(4'h0, 8'd0, 8'h00, 8'd3, 1'b0, 1'b1, 1'b0);
        tick(2);
        chk("wrap_load", result2, 8'h3C);

        // 0xF8+0x18 = 0x10 carry, stores 0x18 at 16
        drive(4'h0, 8'hF8, 8'h18, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(2);
        chk("pre_nop_r2", result2, 8'h10);
        chk("pre_nop_carry", carry_flag, 1'b1);
        // NOP with w_r: no update, no write
        drive(4'hF, 8'h01, 8'h77, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(2);
        chk("nop_r2", result2, 8'h10);
        chk("nop_zero", zero_flag, 1'b0);
        chk("nop_carry", carry_flag, 1'b1);
        drive(4'h8, 8'd16, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk("nop_nowrite", result2, 8'h18);

        // back-to-back write then read: old data first
        drive(4'h8, 8'd16, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1);
        drive(4'h8, 8'd16, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("readfirst_old", result2, 8'h18);
        tick(1);
        chk("readfirst_new", result2, 8'h99);

        // reset mid-store at word 9
        drive(4'h8, 8'd9, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(3);
        drive(4'h8, 8'd9, 8'hEE, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("midrst_r2", result2, 8'h00);
        chk("midrst_carry", carry_flag, 1'b0);
        rst = 1'b1;
        drive(4'h8, 8'd9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(2);
`ifdef DP_MEM_INIT_EN
        chk("midrst_word", result2, 8'd9);
`else
        chk("midrst_word", result2, 8'h5A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
